bdram_bw_hs: RTL and testbench

- Parametrised byte-write block RAM with a valid/ready request port and a valid/ready response port. Successor to the fixed 64-bit SoC data/instruction BRAM.
- Adds selectable width and depth, correct per-lane write enables on every lane, and selectable read-during-write semantics.
- Adds an optional output pipeline register and a response FIFO, so back-pressure from the core never loses data.
- Sits between the core's SRAM-style memory interface and the RAM array in soc_sram_func.

---
 rtl/bdram_bw_hs.sv | 214 +++++++++++++++++++++
 tb/tb_bdram_bw_hs.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bdram_bw_hs.sv
// Byte-write block RAM with valid/ready request and response ports.
// Latency: response visible 1+OUT_REG cycles after accept (fall-through response FIFO).
// Backpressure: credit counter holds req_ready low once RSP_DEPTH responses are owed.
//
// Ports:
//   clka, resetn                   clock, synchronous active-low reset
//   req_valid/req_ready            request handshake; req_wen all-zero means read
//   req_wen, req_addr, req_wdata   per-byte write enable, word address, write data
//   rsp_valid/rsp_ready            response handshake, one response per request, in order
//   rsp_rdata, rsp_err             response word; rsp_err flags an out-of-range address
// Optional macro BDRAM_BW_HS_STATS_EN adds rd_cnt, wr_cnt (saturating) and sticky err_seen.
module bdram_bw_hs #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 14,
    parameter int DEPTH     = 2**ADDR_W,
    parameter int RD_MODE   = 0,
    parameter int OUT_REG   = 0,
    parameter int RSP_DEPTH = 2
) (
    input  logic                clka,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W/8-1:0] req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
`ifdef BDRAM_BW_HS_STATS_EN
    ,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         wr_cnt,
    output logic                err_seen
`endif
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              accept;
    logic              in_range;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     outstanding;

    // Ready depends only on the credit register and reset, never on rsp_ready.
    assign req_ready = resetn && (outstanding < CW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_L);
    assign idx       = req_addr[IW-1:0];

    // ---------------- array: byte-lane write, read-first latch ----------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clka) begin
        if (accept && in_range) begin
            rd_word <= mem[idx];
            for (int i = 0; i < NB; i++) begin
                if (req_wen[i]) begin
                    mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- stage 1: request attributes alongside the read ----------------
    logic              s1_vld;
    logic              s1_err;
    logic [NB-1:0]     s1_wen;
    logic [DATA_W-1:0] s1_wdata;
    logic [DATA_W-1:0] s1_dat;

    always_ff @(posedge clka) begin
        if (!resetn) begin
            s1_vld   <= 1'b0;
            s1_err   <= 1'b0;
            s1_wen   <= '0;
            s1_wdata <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_err   <= !in_range;
                s1_wen   <= req_wen;
                s1_wdata <= req_wdata;
            end
        end
    end

    // Write-first merge is done after the array so the array keeps a plain
    // read-first port; reads have s1_wen==0 so merge returns the stored word.
    always_comb begin
        s1_dat = '0;
        if (!s1_err) begin
            for (int i = 0; i < NB; i++) begin
                s1_dat[i*8 +: 8] = (RD_MODE != 0 && s1_wen[i]) ? s1_wdata[i*8 +: 8]
                                                                : rd_word[i*8 +: 8];
            end
        end
    end

    // ---------------- optional output register ----------------
    logic              in_vld;
    logic              in_err;
    logic [DATA_W-1:0] in_dat;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              s2_vld;
            logic              s2_err;
            logic [DATA_W-1:0] s2_dat;

            always_ff @(posedge clka) begin
                if (!resetn) begin
                    s2_vld <= 1'b0;
                    s2_err <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_err <= s1_err;
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign in_vld = s2_vld;
            assign in_err = s2_err;
            assign in_dat = s2_dat;
        end else begin : g_noreg
            assign in_vld = s1_vld;
            assign in_err = s1_err;
            assign in_dat = s1_dat;
        end
    endgenerate

    // ---------------- fall-through response FIFO ----------------
    logic [DATA_W-1:0] f_dat [0:RSP_DEPTH-1];
    logic              f_err [0:RSP_DEPTH-1];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     f_cnt;
    logic              f_empty;
    logic              pop;
    logic              push;
    logic              f_pop;

    assign f_empty   = (f_cnt == '0);
    assign rsp_valid = !f_empty || in_vld;
    assign rsp_rdata = !f_empty ? f_dat[rd_ptr] : (in_vld ? in_dat : '0);
    assign rsp_err   = !f_empty ? f_err[rd_ptr] : (in_vld && in_err);
    assign pop       = rsp_valid && rsp_ready;
    // An arriving response bypasses storage only when nothing is queued ahead
    // of it and the consumer takes it this cycle.
    assign push      = in_vld && !(f_empty && rsp_ready);
    assign f_pop     = pop && !f_empty;

    always_ff @(posedge clka) begin
        if (push) begin
            f_dat[wr_ptr] <= in_dat;
            f_err[wr_ptr] <= in_err;
        end
    end

    always_ff @(posedge clka) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            f_cnt       <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (f_pop) begin
                rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, f_pop})
                2'b10:   f_cnt <= f_cnt + CW'(1);
                2'b01:   f_cnt <= f_cnt - CW'(1);
                default: ;
            endcase
            // Credits cover requests in the pipeline plus entries in the FIFO.
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase
        end
    end

`ifdef BDRAM_BW_HS_STATS_EN
    always_ff @(posedge clka) begin
        if (!resetn) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            err_seen <= 1'b0;
        end else if (accept) begin
            if (!in_range) begin
                err_seen <= 1'b1;
            end else if (req_wen == '0) begin
                if (rd_cnt != 32'hFFFF_FFFF) rd_cnt <= rd_cnt + 32'd1;
            end else begin
                if (wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bdram_bw_hs.sv
// Testbench for bdram_bw_hs: two instances (read-first/no output reg, write-first/output reg),
// both DEPTH=1000, RSP_DEPTH=2, checked against a word-array + response-queue model.
module tb_bdram_bw_hs;

    localparam int NDUT  = 2;
    localparam int DEPTH = 1000;
    localparam int OREG [NDUT] = '{0, 1};
    localparam int RDM  [NDUT] = '{0, 1};

    logic        clk;
    logic        resetn;
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic [7:0]  req_wen   [NDUT];
    logic [13:0] req_addr  [NDUT];
    logic [63:0] req_wdata [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [63:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];
`ifdef BDRAM_BW_HS_STATS_EN
    logic [31:0] rd_cnt    [NDUT];
    logic [31:0] wr_cnt    [NDUT];
    logic        err_seen  [NDUT];
`endif

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            bdram_bw_hs #(
                .DATA_W(64), .ADDR_W(14), .DEPTH(DEPTH),
                .RD_MODE(RDM[g]), .OUT_REG(OREG[g]), .RSP_DEPTH(2)
            ) u_dut (
                .clka(clk), .resetn(resetn),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]),
                .req_wen(req_wen[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
`ifdef BDRAM_BW_HS_STATS_EN
                , .rd_cnt(rd_cnt[g]), .wr_cnt(wr_cnt[g]), .err_seen(err_seen[g])
`endif
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] d;
        logic        e;
        logic        chk;
    } exp_t;

    exp_t        expq   [NDUT][$];
    logic [63:0] mref   [NDUT][1024];
    bit          mknown [NDUT][1024];
    int          pops   [NDUT];
    bit          last_acc [NDUT];
    bit          hold   [NDUT];
    logic [63:0] hold_d [NDUT];
    logic        hold_e [NDUT];
    int          m_rd   [NDUT];
    int          m_wr   [NDUT];
    bit          m_err  [NDUT];

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_accept(input int k);
        int a;
        exp_t e;
        logic [63:0] old_w;
        logic [63:0] new_w;
        a = int'(req_addr[k]);
        if (a >= DEPTH) begin
            e.d = 64'h0; e.e = 1'b1; e.chk = 1'b1;
            m_err[k] = 1'b1;
        end else begin
            old_w = mref[k][a];
            new_w = old_w;
            for (int i = 0; i < 8; i++)
                if (req_wen[k][i]) new_w[i*8 +: 8] = req_wdata[k][i*8 +: 8];
            e.d   = (RDM[k] != 0) ? new_w : old_w;
            e.e   = 1'b0;
            e.chk = mknown[k][a] || (RDM[k] != 0 && req_wen[k] == 8'hFF);
            mref[k][a] = new_w;
            if (req_wen[k] == 8'hFF) mknown[k][a] = 1'b1;
            if (req_wen[k] == 8'h00) m_rd[k]++;
            else                     m_wr[k]++;
        end
        expq[k].push_back(e);
    endtask

    // Sampled on the falling edge: the handshakes seen here complete on the next rising edge.
    task automatic monitor();
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            if (!resetn) begin
                expq[k].delete();
                last_acc[k] = 1'b0;
                hold[k]     = 1'b0;
                m_rd[k]     = 0;
                m_wr[k]     = 0;
                m_err[k]    = 1'b0;
            end else begin
                if (hold[k]) begin
                    chk($sformatf("hold_valid d%0d", k), 64'(rsp_valid[k]), 64'd1);
                    chk($sformatf("hold_rdata d%0d", k), rsp_rdata[k], hold_d[k]);
                    chk($sformatf("hold_err d%0d", k), 64'(rsp_err[k]), 64'(hold_e[k]));
                end
                if (rsp_valid[k] && rsp_ready[k]) begin
                    pops[k]++;
                    if (expq[k].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp d%0d: got response %h with none owed", k, rsp_rdata[k]);
                    end else begin
                        e = expq[k].pop_front();
                        chk($sformatf("rsp_err d%0d", k), 64'(rsp_err[k]), 64'(e.e));
                        if (e.chk) chk($sformatf("rsp_rdata d%0d", k), rsp_rdata[k], e.d);
                    end
                end
                hold[k]   = rsp_valid[k] && !rsp_ready[k];
                hold_d[k] = rsp_rdata[k];
                hold_e[k] = rsp_err[k];
                last_acc[k] = req_valid[k] && req_ready[k];
                if (last_acc[k]) model_accept(k);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] wen, input logic [13:0] addr, input logic [63:0] wdata);
        bit ok;
        req_wen[k]   = wen;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (last_acc[k]) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid[k] = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout d%0d: addr %0d never accepted", k, addr);
        end
    endtask

    task automatic txn(input int k, input logic [7:0] wen, input logic [13:0] addr, input logic [63:0] wdata,
                       output logic [63:0] d, output logic e, output int lat);
        send(k, wen, addr, wdata);
        lat = 1;
        while (!rsp_valid[k] && lat < 50) begin
            tick();
            lat++;
        end
        d = rsp_rdata[k];
        e = rsp_err[k];
        if (!rsp_valid[k]) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout d%0d: no response for addr %0d", k, addr);
        end
        tick();
    endtask

    task automatic drain(input int k);
        for (int c = 0; c < 60; c++) begin
            if (expq[k].size() == 0) break;
            tick();
        end
        chk($sformatf("drain d%0d", k), 64'(expq[k].size()), 64'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0]  wen;
        logic [13:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp0;
        logic [63:0] exp1;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [63:0] d;
        logic        e;
        int          lat;
        int          acc;
        int          p0;

        tbl[0]  = '{8'hFF, 14'd5,    64'h1122_3344_5566_7788, 64'h0505_0505_0505_0505, 64'h1122_3344_5566_7788, 1'b0};
        tbl[1]  = '{8'hF0, 14'd5,    64'hAAAA_AAAA_BBBB_BBBB, 64'h1122_3344_5566_7788, 64'hAAAA_AAAA_5566_7788, 1'b0};
        tbl[2]  = '{8'h00, 14'd5,    64'h0,                   64'hAAAA_AAAA_5566_7788, 64'hAAAA_AAAA_5566_7788, 1'b0};
        tbl[3]  = '{8'hFF, 14'd9,    64'h0,                   64'h0909_0909_0909_0909, 64'h0,                   1'b0};
        tbl[4]  = '{8'h03, 14'd9,    64'hFFFF,                64'h0,                   64'hFFFF,                1'b0};
        tbl[5]  = '{8'h00, 14'd9,    64'h0,                   64'hFFFF,                64'hFFFF,                1'b0};
        tbl[6]  = '{8'hFF, 14'd1000, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   64'h0,                   1'b1};
        tbl[7]  = '{8'h00, 14'd1000, 64'h0,                   64'h0,                   64'h0,                   1'b1};
        tbl[8]  = '{8'h00, 14'd999,  64'h0,                   64'hE7E7_E7E7_E7E7_E7E7, 64'hE7E7_E7E7_E7E7_E7E7, 1'b0};
        tbl[9]  = '{8'h80, 14'd999,  64'h1200_0000_0000_0000, 64'hE7E7_E7E7_E7E7_E7E7, 64'h12E7_E7E7_E7E7_E7E7, 1'b0};
        tbl[10] = '{8'h00, 14'd999,  64'h0,                   64'h12E7_E7E7_E7E7_E7E7, 64'h12E7_E7E7_E7E7_E7E7, 1'b0};
        tbl[11] = '{8'h00, 14'd1001, 64'h0,                   64'h0,                   64'h0,                   1'b1};

        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k] = 1'b0;
            req_wen[k]   = '0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            rsp_ready[k] = 1'b1;
            pops[k]      = 0;
            for (int a = 0; a < 1024; a++) begin
                mref[k][a]   = '0;
                mknown[k][a] = 1'b0;
            end
        end

        // Reset state
        resetn = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) tick();
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("ready_in_reset d%0d", k), 64'(req_ready[k]), 64'd0);
        resetn = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset_ready d%0d", k), 64'(req_ready[k]), 64'd1);
            chk($sformatf("reset_valid d%0d", k), 64'(rsp_valid[k]), 64'd0);
            chk($sformatf("reset_rdata d%0d", k), rsp_rdata[k], 64'd0);
            chk($sformatf("reset_err d%0d", k), 64'(rsp_err[k]), 64'd0);
        end

        for (int k = 0; k < NDUT; k++) begin
            // Preload: word a = {8{a[7:0]}}
            rsp_ready[k] = 1'b1;
            for (int a = 0; a < 18; a++) begin
                logic [13:0] ad;
                ad = (a < 16) ? 14'(a) : 14'(998 + a - 16);
                send(k, 8'hFF, ad, {8{ad[7:0]}});
            end
            drain(k);

            // Table: one transaction at a time, latency measured from accept edge
            for (int i = 0; i < 12; i++) begin
                txn(k, tbl[i].wen, tbl[i].addr, tbl[i].wdata, d, e, lat);
                chk($sformatf("vec%0d_rdata d%0d", i, k), d, (RDM[k] != 0) ? tbl[i].exp1 : tbl[i].exp0);
                chk($sformatf("vec%0d_err d%0d", i, k), 64'(e), 64'(tbl[i].err));
                chk($sformatf("vec%0d_latency d%0d", i, k), 64'(lat), 64'(1 + OREG[k]));
            end

            // Back-pressure: five reads offered with the consumer stalled
            rsp_ready[k] = 1'b0;
            acc = 0;
            req_wen[k] = 8'h00; req_addr[k] = 14'd1; req_wdata[k] = '0; req_valid[k] = 1'b1;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (last_acc[k]) begin
                    acc++;
                    req_addr[k] = 14'(1 + acc);
                    if (acc == 5) req_valid[k] = 1'b0;
                end
            end
            chk($sformatf("bp_accepted d%0d", k), 64'(acc), 64'd2);
            chk($sformatf("bp_ready_low d%0d", k), 64'(req_ready[k]), 64'd0);
            p0 = pops[k];
            rsp_ready[k] = 1'b1;
            for (int c = 0; c < 40; c++) begin
                if (acc == 5 && expq[k].size() == 0) break;
                tick();
                if (last_acc[k]) begin
                    acc++;
                    req_addr[k] = 14'(1 + acc);
                    if (acc == 5) req_valid[k] = 1'b0;
                end
            end
            req_valid[k] = 1'b0;
            chk($sformatf("bp_total_accepted d%0d", k), 64'(acc), 64'd5);
            chk($sformatf("bp_responses d%0d", k), 64'(pops[k] - p0), 64'd5);

            // Reset with responses in flight
            send(k, 8'hFF, 14'd3, 64'h55);
            send(k, 8'h00, 14'd1, 64'h0);
            send(k, 8'h00, 14'd2, 64'h0);
            resetn = 1'b0;
            #1;
            chk($sformatf("rst_mid_ready_low d%0d", k), 64'(req_ready[k]), 64'd0);
            tick();
            resetn = 1'b1;
            #1;
            chk($sformatf("rst_mid_valid d%0d", k), 64'(rsp_valid[k]), 64'd0);
            chk($sformatf("rst_mid_rdata d%0d", k), rsp_rdata[k], 64'd0);
            chk($sformatf("rst_mid_ready d%0d", k), 64'(req_ready[k]), 64'd1);
`ifdef BDRAM_BW_HS_STATS_EN
            chk($sformatf("rst_rd_cnt d%0d", k), 64'(rd_cnt[k]), 64'd0);
            chk($sformatf("rst_wr_cnt d%0d", k), 64'(wr_cnt[k]), 64'd0);
            chk($sformatf("rst_err_seen d%0d", k), 64'(err_seen[k]), 64'd0);
`endif
            txn(k, 8'hFF, 14'd1000, 64'h1234, d, e, lat);
            chk($sformatf("oor_wr_rdata d%0d", k), d, 64'd0);
            chk($sformatf("oor_wr_err d%0d", k), 64'(e), 64'd1);
            txn(k, 8'h00, 14'd1000, 64'h0, d, e, lat);
            chk($sformatf("oor_rd_rdata d%0d", k), d, 64'd0);
            chk($sformatf("oor_rd_err d%0d", k), 64'(e), 64'd1);
`ifdef BDRAM_BW_HS_STATS_EN
            chk($sformatf("oor_err_seen d%0d", k), 64'(err_seen[k]), 64'd1);
            chk($sformatf("oor_rd_cnt d%0d", k), 64'(rd_cnt[k]), 64'd0);
            chk($sformatf("oor_wr_cnt d%0d", k), 64'(wr_cnt[k]), 64'd0);
`endif
            txn(k, 8'h00, 14'd3, 64'h0, d, e, lat);
            chk($sformatf("rst_retained d%0d", k), d, 64'h55);

            // Randomized traffic with random consumer stalls
            for (int c = 0; c < 400; c++) begin
                if (!req_valid[k] || last_acc[k]) begin
                    int r;
                    req_valid[k] = ($urandom_range(0, 9) < 7);
                    r = $urandom_range(0, 3);
                    req_wen[k] = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
                    req_addr[k] = ($urandom_range(0, 9) == 0) ? 14'(998 + $urandom_range(0, 3))
                                                              : 14'($urandom_range(0, 15));
                    req_wdata[k] = {$urandom, $urandom};
                end
                rsp_ready[k] = ($urandom_range(0, 9) < 7);
                tick();
            end
            req_valid[k] = 1'b0;
            rsp_ready[k] = 1'b1;
            drain(k);
`ifdef BDRAM_BW_HS_STATS_EN
            chk($sformatf("stat_rd_cnt d%0d", k), 64'(rd_cnt[k]), 64'(m_rd[k]));
            chk($sformatf("stat_wr_cnt d%0d", k), 64'(wr_cnt[k]), 64'(m_wr[k]));
            chk($sformatf("stat_err_seen d%0d", k), 64'(err_seen[k]), 64'(m_err[k]));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
